// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch stage. Issues word-aligned requests,
// buffers in-order responses in a small prefetch FIFO and presents {pc, inst}
// to the decoder. A redirect flushes buffered entries and drops in-flight ones.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int unsigned     CW           = $clog2(DEPTH + 1);
    localparam int unsigned     PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE      = CW'(1'b1);
    localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(DEPTH);
    localparam logic [PW-1:0]   PTR_ZERO     = {PW{1'b0}};
    localparam logic [PW-1:0]   PTR_ONE      = PW'(1'b1);
    localparam logic [PW-1:0]   PTR_LAST     = PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(3'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(2'b11);

    // Architectural state
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   discard_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [XLEN-1:0] fifo_pc_r   [DEPTH];
    logic [XLEN-1:0] fifo_data_r [DEPTH];

    // Per-cycle decode
    logic            inst_valid_s;
    logic            req_valid_s;
    logic            pop_s;
    logic            push_s;
    logic            rsp_ok_s;
    logic            req_fire_s;
    logic [CW:0]     credit_sum_s;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [XLEN-1:0] redirect_target_s;

    // Circular pointer advance for a FIFO whose depth need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? PTR_ZERO : (ptr + PTR_ONE);
    endfunction

    // Handshake decode: the slot being popped this cycle already counts as free
    // credit, which is what lets a 2-entry FIFO sustain one instruction per cycle.
    always_comb begin
        inst_valid_s      = (count_r != CNT_ZERO) && !redirect_valid && !rst;
        pop_s             = inst_valid_s && inst_ready;
        credit_sum_s      = {1'b0, outstanding_r} + {1'b0, count_r}
                            - (pop_s ? {1'b0, CNT_ONE} : {(CW+1){1'b0}});
        req_valid_s       = !rst && !redirect_valid && (credit_sum_s < CREDIT_LIMIT);
        req_fire_s        = req_valid_s && imem_req_ready;
        rsp_ok_s          = imem_rsp_valid && (outstanding_r != CNT_ZERO) && !rst;
        push_s            = rsp_ok_s && !redirect_valid && (discard_r == CNT_ZERO);
        redirect_target_s = redirect_pc & ALIGN_MASK;
        case ({req_fire_s, rsp_ok_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = inst_valid_s;
    assign inst_pc        = fifo_pc_r[rd_ptr_r];
    assign inst_data      = fifo_data_r[rd_ptr_r];

    // Fetch PC, credit counters and FIFO pointers; redirect flushes and arms discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            count_r       <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            wr_ptr_r      <= PTR_ZERO;
        end else if (redirect_valid) begin
            pc_r          <= redirect_target_s;
            rsp_pc_r      <= redirect_target_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= outstanding_nxt_s;
            count_r       <= CNT_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            wr_ptr_r      <= PTR_ZERO;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (req_fire_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (rsp_ok_s && (discard_r != CNT_ZERO)) begin
                discard_r <= discard_r - CNT_ONE;
            end
            if (push_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Prefetch FIFO storage: each accepted response is written with its PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= {XLEN{1'b0}};
                fifo_data_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
            fifo_data_r[wr_ptr_r] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (DEPTH=2, RESET_PC=0). A small
// in-order memory model answers each accepted request after a chosen latency
// with data = addr ^ 32'hA5A5_0000; expected PCs per cycle are hand-derived.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0000_0000;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_data(inst_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          last_due = 0;
    int          q_due[$];
    logic [31:0] q_addr[$];

    // Redirect-with-in-flight table (memory latency 3, redirect at cycle 2)
    localparam bit          D_RV [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] D_RA [10] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h1000, 32'h1004,
                                          32'h0, 32'h0, 32'h1008, 32'h100C};
    localparam bit          D_IV [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] D_IP [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'h1000, 32'h1004};
    // Redirect coincident with a response (latency 1, redirect at cycle 2)
    localparam bit          E_RV [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [31:0] E_RA [7] = '{32'h0, 32'h4, 32'h0, 32'h2000, 32'h2004, 32'h2008, 32'h200C};
    localparam bit          E_IV [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] E_IP [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h2004};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] a);
        check_eq({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
        if (v) check_eq({tag, ".req_addr"}, imem_req_addr, a);
    endtask

    task automatic check_inst(input string tag, input logic v, input logic [31:0] pc);
        check_eq({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
        if (v) begin
            check_eq({tag, ".inst_pc"}, inst_pc, pc);
            check_eq({tag, ".inst_data"}, inst_data, pc ^ KEY);
        end
    endtask

    // Record an accepted request, advance one clock, then drive any due response.
    task automatic tick();
        int d;
        if (imem_req_valid && imem_req_ready) begin
            d = cyc + mem_lat;
            if (d <= last_due) d = last_due + 1;
            q_addr.push_back(imem_req_addr);
            q_due.push_back(d);
            last_due = d;
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = q_addr[0] ^ KEY;
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        q_due.delete(); q_addr.delete(); last_due = cyc;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
            check_eq("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        // Streaming: 1-cycle memory, always-ready consumer
        do_reset();
        for (int k = 0; k < 12; k++) begin
            #1;
            check_req($sformatf("stream%0d", k), 1'b1, 32'(4 * k));
            check_inst($sformatf("stream%0d", k), k >= 2, 32'(4 * (k - 2)));
            tick();
        end

        // Consumer backpressure for 10 cycles, then release
        do_reset();
        for (int k = 0; k < 16; k++) begin
            inst_ready = (k >= 10);
            #1;
            check_req($sformatf("bp%0d", k), (k < 2) || (k >= 10), (k < 2) ? 32'(4 * k) : 32'(4 * (k - 8)));
            check_inst($sformatf("bp%0d", k), k >= 2, (k < 10) ? 32'h0 : 32'(4 * (k - 10)));
            tick();
        end

        // Memory stall on the request for address 0x8
        do_reset();
        for (int k = 0; k < 11; k++) begin
            imem_req_ready = !((k >= 2) && (k <= 6));
            #1;
            check_req($sformatf("stall%0d", k), 1'b1,
                      (k < 2) ? 32'(4 * k) : ((k <= 7) ? 32'h8 : 32'(8 + 4 * (k - 7))));
            check_inst($sformatf("stall%0d", k), (k == 2) || (k == 3) || (k >= 9),
                       (k == 2) ? 32'h0 : ((k == 3) ? 32'h4 : 32'(8 + 4 * (k - 9))));
            tick();
        end

        // Redirect to 0x1003 with two requests in flight
        do_reset();
        mem_lat = 3;
        for (int k = 0; k < 10; k++) begin
            redirect_valid = (k == 2);
            redirect_pc    = 32'h0000_1003;
            #1;
            check_req($sformatf("redir%0d", k), D_RV[k], D_RA[k]);
            check_inst($sformatf("redir%0d", k), D_IV[k], D_IP[k]);
            tick();
        end
        redirect_valid = 1'b0;

        // Redirect landing together with a response and a ready consumer
        do_reset();
        for (int k = 0; k < 7; k++) begin
            redirect_valid = (k == 2);
            redirect_pc    = 32'h0000_2000;
            #1;
            check_req($sformatf("redrsp%0d", k), E_RV[k], E_RA[k]);
            check_inst($sformatf("redrsp%0d", k), E_IV[k], E_IP[k]);
            tick();
        end
        redirect_valid = 1'b0;

        // Reset with one buffered entry and one request outstanding
        do_reset();
        inst_ready = 1'b0;
        #1; check_req("mid0", 1'b1, 32'h0); tick();
        mem_lat = 6;
        #1; check_req("mid1", 1'b1, 32'h4); tick();
        #1; check_inst("mid2.pre", 1'b1, 32'h0);
        rst = 1'b1;
        #1;
        check_req("mid2.rst", 1'b0, 32'h0);
        check_inst("mid2.rst", 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0; imem_req_ready = 1'b0; mem_lat = 1;
        for (int k = 4; k < 8; k++) begin
            #1;
            check_req($sformatf("mid%0d", k), 1'b1, 32'h0);
            check_inst($sformatf("mid%0d", k), 1'b0, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        check_req("mid8", 1'b1, 32'h0);
        check_inst("mid8", 1'b0, 32'h0);
        tick();
        inst_ready = 1'b1;
        #1;
        check_req("mid9", 1'b1, 32'h4);
        check_inst("mid9", 1'b0, 32'h0);
        tick();
        #1;
        check_inst("mid10", 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
